// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry
// and the scrub FSM state encoding.
package regfile_mp_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } scrub_state_e;

endpackage

// File: rtl/regfile_scrub.sv
// Sequential scrub controller: walks a pointer from 1 to the last entry,
// asserting a clear-enable on each step, and reports Busy meanwhile.
module regfile_scrub
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Clr,
    output logic              Busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};

    scrub_state_e      state_r;
    scrub_state_e      state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nxt_s;
    logic              busy_r;

    // Next-state and pointer update for the scrub FSM.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (Clr) begin
                    state_nxt_s = CLEAR;
                    ptr_nxt_s   = PTR_FIRST;
                end else begin
                    state_nxt_s = IDLE;
                    ptr_nxt_s   = ptr_r;
                end
            end
            CLEAR: begin
                // Terminal entry ends the scrub; the pointer holds rather than wraps.
                if (ptr_r == PTR_LAST) begin
                    state_nxt_s = IDLE;
                    ptr_nxt_s   = ptr_r;
                end else begin
                    state_nxt_s = CLEAR;
                    ptr_nxt_s   = ptr_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ptr_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, pointer and registered busy flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            busy_r  <= (state_nxt_s == CLEAR);
        end
    end

    assign Busy   = busy_r;
    assign clr_en = busy_r;
    assign ptr    = ptr_r;

endmodule

// File: rtl/regfile_mp.sv
// Three-read / two-write register file with r0 hardwired to zero, optional
// write-to-read forwarding and a sequential scrub of all entries.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    input  logic [ADDR_W-1:0] RS3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] RD3,
    input  logic [ADDR_W-1:0] WA_A,
    input  logic [ADDR_W-1:0] WA_B,
    input  logic [DATA_W-1:0] WD_A,
    input  logic [DATA_W-1:0] WD_B,
    input  logic              WE_A,
    input  logic              WE_B,
    input  logic              Clr,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              busy_s;
    logic              clr_en_s;
    logic [ADDR_W-1:0] ptr_s;
    logic              fwd_en_s;
    logic [ADDR_W-1:0] rs_s [3];
    logic [DATA_W-1:0] rd_s [3];

    regfile_scrub #(
        .ADDR_W (ADDR_W)
    ) u_scrub (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Clr     (Clr),
        .Busy    (busy_s),
        .clr_en  (clr_en_s),
        .ptr     (ptr_s)
    );

    // Storage: async clear, scrub has priority, port B written last so it wins.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_ZERO;
            end
        end else if (clr_en_s) begin
            mem_r[ptr_s] <= DATA_ZERO;
        end else if (!busy_s) begin
            if (WE_A && (WA_A != ADDR_ZERO)) begin
                mem_r[WA_A] <= WD_A;
            end
            if (WE_B && (WA_B != ADDR_ZERO)) begin
                mem_r[WA_B] <= WD_B;
            end
        end
    end

    assign fwd_en_s = (BYPASS != 0) && !busy_s;
    assign rs_s[0]  = RS1;
    assign rs_s[1]  = RS2;
    assign rs_s[2]  = RS3;

    // Combinational read muxes with forwarding; port B data beats port A.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_s[p] = DATA_ZERO;
            if (!Reset_n || (rs_s[p] == ADDR_ZERO)) begin
                rd_s[p] = DATA_ZERO;
            end else if (fwd_en_s && WE_B && (WA_B == rs_s[p])) begin
                rd_s[p] = WD_B;
            end else if (fwd_en_s && WE_A && (WA_A == rs_s[p])) begin
                rd_s[p] = WD_A;
            end else begin
                rd_s[p] = mem_r[rs_s[p]];
            end
        end
    end

    assign RD1  = rd_s[0];
    assign RD2  = rd_s[1];
    assign RD3  = rd_s[2];
    assign Busy = busy_s;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries, entry 0 hardwired zero.
REQ-003 Parameter BYPASS, default 1, 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-004 Clk  in  1  single clock, all state updates on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 RS1, RS2, RS3  in  ADDR_W each  read addresses, ports 1..3.
REQ-007 RD1, RD2, RD3  out  DATA_W each  read data, ports 1..3; each RDn is driven from its own RSn.
REQ-008 WA_A, WA_B  in  ADDR_W each  write addresses, ports A and B.
REQ-009 WD_A, WD_B  in  DATA_W each  write data, ports A and B.
REQ-010 WE_A, WE_B  in  1 each  write enables, ports A and B.
REQ-011 Clr  in  1  single-cycle request to start a sequential scrub of all entries.
REQ-012 Busy  out  1  high while a scrub is in progress.

Function
REQ-013 Reads SHALL be combinational: RDn = 0 when RSn == 0, otherwise entry[RSn], with bypass applied per REQ-014.
REQ-014 With BYPASS=1, Busy=0 and WE_x=1 with WA_x == RSn != 0, RDn SHALL return WD_x; WD_B SHALL take priority when both ports match.
REQ-015 With BYPASS=0, or while Busy=1, reads SHALL return stored contents only.
REQ-016 On a rising edge with Busy=0, WE_A=1 and WA_A != 0, entry[WA_A] SHALL be loaded with WD_A; port B SHALL behave the same way.
REQ-017 Writes to address 0 SHALL be discarded.
REQ-018 If WE_A=WE_B=1 and WA_A == WA_B, port B SHALL win.
REQ-019 The scrub FSM SHALL have two states: IDLE and CLEAR. Reset state is IDLE.
REQ-020 In IDLE, Clr=1 on a rising edge SHALL move the FSM to CLEAR and load the scrub pointer with 1. Any writes in that same cycle SHALL still complete.
REQ-021 In CLEAR, each rising edge SHALL zero entry[pointer] and increment the pointer.
REQ-022 When the entry at pointer 2**ADDR_W-1 is zeroed, the FSM SHALL return to IDLE; the scrub takes exactly 2**ADDR_W-1 cycles.
REQ-023 Busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-024 In CLEAR, WE_A and WE_B SHALL be ignored, and Clr SHALL be ignored (no restart).
REQ-025 The pointer SHALL be ADDR_W bits wide and SHALL NOT wrap; exit is on the terminal value.

Reset
REQ-026 When Reset_n=0, asynchronously and regardless of Clk: every entry SHALL be 0, the FSM SHALL be IDLE, the pointer SHALL be 0, Busy SHALL be 0, and RD1..RD3 SHALL read 0.
REQ-027 Reset asserted mid-scrub SHALL abort the scrub; after release, the block SHALL be in IDLE with all entries 0.
REQ-028 The first rising edge after Reset_n deasserts SHALL accept writes and Clr normally.

Structure
REQ-029 State encodings (IDLE, CLEAR) and the default DATA_W/ADDR_W values SHALL live in the shared datapath package.
REQ-030 The scrub FSM and pointer SHALL be one sub-module, regfile_scrub, with outputs Busy, a clear-enable and the pointer. The storage array and bypass muxing SHALL stay in regfile_mp.

Verification
REQ-031 Single write: write 0xDEADBEEF to r5 via port A, next cycle RS1=RS2=RS3=5 -> all three read 0xDEADBEEF. Distinct ports: RS1=5, RS2=0 -> RD2=0.
REQ-032 Port conflict: WE_A=WE_B=1, WA_A=WA_B=7, WD_A=0x1, WD_B=0x2 -> r7=0x2. Same cycle with RS3=7 and BYPASS=1 -> RD3=0x2.
REQ-033 Write to r0 of 0xFFFFFFFF -> RD1 with RS1=0 reads 0. BYPASS=0 build: same-cycle read of a written register returns the old value.
REQ-034 Scrub: fill r1..r31 with nonzero data, pulse Clr -> Busy=1 for exactly 31 cycles, writes in that window are ignored, all entries read 0 afterwards.
REQ-035 Reset mid-scrub: drive Reset_n low at scrub cycle 10 -> Busy=0 immediately; after release, all entries read 0, and a write on the first edge succeeds.
REQ-036 Async reset: drive Reset_n low between clock edges with r3=0x55 -> RD1 (RS1=3) reads 0 before the next edge.
